// File: rtl/heli_motion_ctrl_pkg.sv
// Shared definitions for the helicopter motion sequencer: FSM state codes,
// screen geometry and sprite size.
package heli_motion_ctrl_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 11;
  localparam int SPRITE_H = 11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRAW  = 3'd1;
  localparam state_t ST_HOLD  = 3'd2;
  localparam state_t ST_ERASE = 3'd3;
  localparam state_t ST_MOVE  = 3'd4;
  localparam state_t ST_CRASH = 3'd5;

  // True in the two states where the drawer is running a pass.
  function automatic logic is_pass(input state_t s);
    return (s == ST_DRAW) || (s == ST_ERASE);
  endfunction

endpackage

// File: rtl/heli_motion_ctrl_frame_timer.sv
// Frame hold counter: cleared while drawing, counts while holding, and flags
// the last cycle of the hold period.
module frame_timer #(
  parameter int TICKS = 833334,
  parameter int W     = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(TICKS - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_r;

  // Hold-period counter; wraps after the last tick so it never overruns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = run && (cnt_r == LAST);

endmodule

// File: rtl/heli_motion_ctrl.sv
// Frame sequencer for the helicopter sprite: draw, hold, erase, move, and
// crash detection against the vertical play-field limits.
module heli_motion_ctrl
  import heli_motion_ctrl_pkg::*;
#(
  parameter int FRAME_TICKS = 833334,
  parameter int X_START     = 120,
  parameter int Y_START     = 20,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 109,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       up,
  input  logic       draw_done,
  output logic       draw_enable,
  output logic       draw_erase,
  output logic [7:0] obj_x,
  output logic [6:0] obj_y,
  output logic       crash
);

  localparam logic [7:0] X_START_8 = 8'(X_START);
  localparam logic [6:0] Y_START_7 = 7'(Y_START);
  localparam logic [7:0] Y_MIN_8   = 8'(Y_MIN);
  localparam logic [7:0] Y_MAX_8   = 8'(Y_MAX);
  localparam logic [7:0] STEP_8    = 8'(STEP);
  localparam logic [6:0] STEP_7    = 7'(STEP);

  logic       up_s1_r;
  logic       up_s2_r;
  logic       up_req_r;
  state_t     state_r;
  state_t     state_s;
  logic [6:0] obj_y_r;
  logic [6:0] obj_y_s;
  logic [7:0] y_ext_s;
  logic       timer_tick_s;
  logic       draw_enable_r;
  logic       draw_erase_r;
  logic       crash_r;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      up_s1_r <= 1'b0;
      up_s2_r <= 1'b0;
    end else begin
      up_s1_r <= up;
      up_s2_r <= up_s1_r;
    end
  end

  // Sticky press flag; MOVE always exits after one cycle, so it clears there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      up_req_r <= 1'b0;
    end else if (state_r == ST_MOVE) begin
      up_req_r <= 1'b0;
    end else if (up_s2_r && ((state_r == ST_HOLD) || (state_r == ST_ERASE))) begin
      up_req_r <= 1'b1;
    end else begin
      up_req_r <= up_req_r;
    end
  end

  frame_timer #(
    .TICKS (FRAME_TICKS)
  ) u_frame_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_r == ST_DRAW),
    .run    (state_r == ST_HOLD),
    .tick   (timer_tick_s)
  );

  // Widened copy so y + STEP cannot wrap in the bottom-edge compare.
  assign y_ext_s = {1'b0, obj_y_r};

  // Next-state and next-position logic.
  always_comb begin
    state_s = state_r;
    obj_y_s = obj_y_r;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          state_s = ST_DRAW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (draw_done) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_DRAW;
        end
      end
      ST_HOLD: begin
        if (timer_tick_s) begin
          state_s = ST_ERASE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_ERASE: begin
        if (draw_done) begin
          state_s = ST_MOVE;
        end else begin
          state_s = ST_ERASE;
        end
      end
      ST_MOVE: begin
        if (up_req_r) begin
          if (y_ext_s < (Y_MIN_8 + STEP_8)) begin
            state_s = ST_CRASH;
          end else begin
            obj_y_s = obj_y_r - STEP_7;
            state_s = ST_DRAW;
          end
        end else begin
          if ((y_ext_s + STEP_8) > Y_MAX_8) begin
            state_s = ST_CRASH;
          end else begin
            obj_y_s = obj_y_r + STEP_7;
            state_s = ST_DRAW;
          end
        end
      end
      ST_CRASH: begin
        if (go) begin
          obj_y_s = Y_START_7;
          state_s = ST_DRAW;
        end else begin
          state_s = ST_CRASH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, position and Moore outputs; outputs decode the next state so they
  // line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      obj_y_r       <= Y_START_7;
      draw_enable_r <= 1'b0;
      draw_erase_r  <= 1'b0;
      crash_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      obj_y_r       <= obj_y_s;
      draw_enable_r <= is_pass(state_s);
      draw_erase_r  <= (state_s == ST_ERASE);
      crash_r       <= (state_s == ST_CRASH);
    end
  end

  assign draw_enable = draw_enable_r;
  assign draw_erase  = draw_erase_r;
  assign crash       = crash_r;
  assign obj_x       = X_START_8;
  assign obj_y       = obj_y_r;

endmodule

// File: tb/tb_heli_motion_ctrl.sv
// Randomized self-checking bench for heli_motion_ctrl with a frame-level
// reference model and a drawer model that answers 5 cycles after enable.
module tb_heli_motion_ctrl;

  localparam int FT     = 8;
  localparam int XS     = 120;
  localparam int YS     = 20;
  localparam int YLO    = 0;
  localparam int YHI    = 109;
  localparam int DLAT   = 5;

  localparam int P_IDLE  = 0;
  localparam int P_DRAW  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_ERASE = 3;
  localparam int P_MOVE  = 4;
  localparam int P_CRASH = 5;

  logic       clk;
  logic       resetn;
  logic       go;
  logic       up;
  logic       draw_done;
  logic       draw_enable;
  logic       draw_erase;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic       crash;

  int vectors;
  int miscompares;
  bit chk_en;
  bit stray_en;

  heli_motion_ctrl #(
    .FRAME_TICKS (FT),
    .X_START     (XS),
    .Y_START     (YS),
    .Y_MIN       (YLO),
    .Y_MAX       (YHI),
    .STEP        (1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go),
    .up          (up),
    .draw_done   (draw_done),
    .draw_enable (draw_enable),
    .draw_erase  (draw_erase),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .crash       (crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which phase of the frame we are in, hold cycles left,
  // position as a plain integer, and the button as seen after two flops.
  int m_phase;
  int m_hold_left;
  int m_y;
  bit m_s1;
  bit m_s2;
  bit m_req;

  function automatic int wanted_y(input int y, input bit req);
    return req ? (y - 1) : (y + 1);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase     <= P_IDLE;
      m_hold_left <= 0;
      m_y         <= YS;
      m_s1        <= 1'b0;
      m_s2        <= 1'b0;
      m_req       <= 1'b0;
    end else begin
      m_s1 <= up;
      m_s2 <= m_s1;
      if (m_phase == P_MOVE)
        m_req <= 1'b0;
      else if (m_s2 && (m_phase == P_HOLD || m_phase == P_ERASE))
        m_req <= 1'b1;
      case (m_phase)
        P_IDLE:  if (go) m_phase <= P_DRAW;
        P_DRAW:  if (draw_done) begin m_phase <= P_HOLD; m_hold_left <= FT; end
        P_HOLD:  if (m_hold_left == 1) m_phase <= P_ERASE; else m_hold_left <= m_hold_left - 1;
        P_ERASE: if (draw_done) m_phase <= P_MOVE;
        P_MOVE: begin
          if (wanted_y(m_y, m_req) < YLO || wanted_y(m_y, m_req) > YHI)
            m_phase <= P_CRASH;
          else begin
            m_y     <= wanted_y(m_y, m_req);
            m_phase <= P_DRAW;
          end
        end
        P_CRASH: if (go) begin m_y <= YS; m_phase <= P_DRAW; end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_en;
      logic e_er;
      logic e_cr;
      e_en = (m_phase == P_DRAW) || (m_phase == P_ERASE);
      e_er = (m_phase == P_ERASE);
      e_cr = (m_phase == P_CRASH);
      vectors = vectors + 1;
      if (draw_enable !== e_en || draw_erase !== e_er || crash !== e_cr ||
          obj_x !== 8'(XS) || obj_y !== 7'(m_y)) begin
        miscompares = miscompares + 1;
        $display("FAIL model t=%0t: en/erase/crash/x/y got %b%b%b/%0d/%0d expected %b%b%b/%0d/%0d",
                 $time, draw_enable, draw_erase, crash, obj_x, obj_y,
                 e_en, e_er, e_cr, XS, m_y);
      end
    end
  end

  // Drawer model: done pulse 5 cycles after enable rises, optional stray pulses.
  int  lat;
  bit  prev_en;
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      lat       = 0;
      prev_en   = 1'b0;
      draw_done = 1'b0;
    end else begin
      draw_done = 1'b0;
      if (draw_enable && !prev_en)
        lat = DLAT;
      else if (lat > 0) begin
        lat = lat - 1;
        if (lat == 0) draw_done = 1'b1;
      end else if (stray_en && !draw_enable && $urandom_range(0, 5) == 0)
        draw_done = 1'b1;
      prev_en = draw_enable;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // which: 0 crash, 1 draw pass, 2 erase pass, 3 drawer idle
  task automatic wait_sig(input int which, input int budget, input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n = n + 1;
      case (which)
        0:       hit = crash;
        1:       hit = draw_enable && !draw_erase;
        2:       hit = draw_enable && draw_erase;
        3:       hit = !draw_enable;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL timeout %s: got no event after %0d cycles, expected within %0d", name, n, budget);
    end
  endtask

  task automatic pulse_go();
    @(posedge clk); #2; go = 1'b1;
    @(posedge clk); #2; go = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    stray_en    = 1'b0;
    resetn      = 1'b0;
    go          = 1'b0;
    up          = 1'b0;
    draw_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_en", draw_enable, 0);
    check("rst_erase", draw_erase, 0);
    check("rst_crash", crash, 0);
    check("rst_x", obj_x, 120);
    check("rst_y", obj_y, 20);
    resetn = 1'b1;

    // First frame: go, draw pass, eight hold cycles, erase pass.
    pulse_go();
    @(negedge clk);
    check("go_en", draw_enable, 1);
    check("go_erase", draw_erase, 0);
    check("go_y", obj_y, 20);
    stray_en = 1'b1;
    wait_sig(3, 50, "draw_end");
    n = 0;
    while (!draw_enable && n < 50) begin
      n = n + 1;
      @(negedge clk);
    end
    check("hold_cycles", n, 8);
    check("erase_mode", draw_erase, 1);

    // Gravity: three frames down.
    for (int k = 1; k <= 3; k++) begin
      wait_sig(1, 100, "fall_draw");
      check("fall_y", obj_y, 20 + k);
      wait_sig(2, 100, "fall_erase");
    end

    // Button held for two frames.
    up = 1'b1;
    wait_sig(2, 100, "up_erase1");
    wait_sig(1, 100, "up_draw1");
    check("up_y1", obj_y, 22);
    wait_sig(2, 100, "up_erase2");
    wait_sig(1, 100, "up_draw2");
    check("up_y2", obj_y, 21);
    up = 1'b0;

    // Single-cycle press in the middle of HOLD.
    wait_sig(3, 100, "pulse_hold");
    repeat (3) @(negedge clk);
    @(posedge clk); #2; up = 1'b1;
    @(posedge clk); #2; up = 1'b0;
    wait_sig(2, 100, "pulse_erase");
    wait_sig(1, 100, "pulse_draw");
    check("pulse_y", obj_y, 20);

    // Fall to the bottom edge.
    wait_sig(0, 4000, "bottom_crash");
    check("bot_y", obj_y, 109);
    check("bot_crash", crash, 1);
    check("bot_en", draw_enable, 0);
    repeat (4) @(negedge clk);
    check("bot_stays", crash, 1);

    pulse_go();
    @(negedge clk);
    check("restart_y", obj_y, 20);
    check("restart_en", draw_enable, 1);
    check("restart_crash", crash, 0);

    // Climb to the top edge.
    up = 1'b1;
    wait_sig(0, 2000, "top_crash");
    check("top_y", obj_y, 0);
    check("top_crash", crash, 1);
    up = 1'b0;

    // Random play.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 7) == 0) up = ~up;
      go = ($urandom_range(0, 39) == 0);
    end

    // Reset in the middle of an erase pass.
    go = 1'b1;
    up = 1'b0;
    wait_sig(2, 3000, "erase_for_reset");
    go = 1'b0;
    @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_en", draw_enable, 0);
    check("async_erase", draw_erase, 0);
    check("async_crash", crash, 0);
    check("async_y", obj_y, 20);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_stray_en", draw_enable, 0);
    pulse_go();

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 5) == 0) up = ~up;
      go = ($urandom_range(0, 29) == 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
